// File: rtl/memctrl_rr.sv
// Round-robin byte-serial memory controller: NUM_CH requesters share one 8-bit
// RAM/IO bus with byte/half/word accesses and sign/zero-extended loads.
module memctrl_rr #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [2*NUM_CH-1:0]      size,
  input  logic [NUM_CH-1:0]        uns,
  input  logic [ADDR_W*NUM_CH-1:0] addr,
  input  logic [32*NUM_CH-1:0]     wdata,
  output logic [NUM_CH-1:0]        done,
  output logic [31:0]              rdata,
  output logic                     busy
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LAST
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   ch_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx_q;
  logic [23:0]       rbuf;
  logic [31:0]       mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic [NUM_CH-1:0] done_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [31:0]       wdata_a [NUM_CH];
  logic [1:0]        size_a  [NUM_CH];
  logic [NUM_CH-1:0] cand;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign addr_a[c]  = addr[c*ADDR_W +: ADDR_W];
    assign wdata_a[c] = wdata[c*32 +: 32];
    assign size_a[c]  = size[c*2 +: 2];
    // IO targets are only eligible while the UART can accept another byte
    assign cand[c]    = req[c] && !(io_buffer_full && (addr_a[c][17:16] == IO_SEL));
  end

  logic            gnt_valid;
  logic [CH_W-1:0] gnt_ch;
  logic [CH_W-1:0] ptr_next;

  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      j = (i + 32'(ptr)) % NUM_CH;
      if (!gnt_valid && cand[j]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_W'(j);
      end
    end
  end

  assign ptr_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

  logic [1:0]  last_idx;
  logic [7:0]  next_byte;
  logic [31:0] ld_ext;

  always_comb begin
    case (size_q)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    next_byte = wdata_q[15:8];
      2'd1:    next_byte = wdata_q[23:16];
      default: next_byte = wdata_q[31:24];
    endcase
  end

  // The final byte is taken straight from mem_din while in LAST
  always_comb begin
    case (size_q)
      2'd0:    ld_ext = {{24{mem_din[7] & ~uns_q}}, mem_din};
      2'd1:    ld_ext = {{16{mem_din[7] & ~uns_q}}, mem_din, rbuf[7:0]};
      default: ld_ext = {mem_din, rbuf};
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      ptr        <= '0;
      ch_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      idx_q      <= '0;
      rbuf       <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      done_q     <= '0;
      rdata_q    <= '0;
    end else if (rdy_in) begin
      done_q  <= '0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (!clear && gnt_valid) begin
            ch_q       <= gnt_ch;
            we_q       <= we[gnt_ch];
            size_q     <= size_a[gnt_ch];
            uns_q      <= uns[gnt_ch];
            wdata_q    <= wdata_a[gnt_ch];
            mem_a_q    <= 32'(addr_a[gnt_ch]);
            mem_dout_q <= wdata_a[gnt_ch][7:0];
            mem_wr_q   <= we[gnt_ch];
            idx_q      <= '0;
            ptr        <= ptr_next;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (clear && !we_q) begin
            state    <= IDLE;
            mem_wr_q <= 1'b0;
          end else begin
            // Byte k-1 arrives on mem_din while byte k's address is presented
            if (!we_q) begin
              case (idx_q)
                2'd1:    rbuf[7:0]   <= mem_din;
                2'd2:    rbuf[15:8]  <= mem_din;
                2'd3:    rbuf[23:16] <= mem_din;
                default: ;
              endcase
            end
            if (idx_q == last_idx) begin
              mem_wr_q <= 1'b0;
              if (we_q) begin
                done_q[ch_q] <= 1'b1;
                state        <= IDLE;
              end else begin
                state <= LAST;
              end
            end else begin
              idx_q      <= idx_q + 2'd1;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= next_byte;
            end
          end
        end
        LAST: begin
          state <= IDLE;
          if (!clear) begin
            done_q[ch_q] <= 1'b1;
            rdata_q      <= ld_ext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rdy_in gates the strobes so a frozen cycle never writes or completes
  assign mem_wr   = mem_wr_q & rdy_in;
  assign done     = done_q & {NUM_CH{rdy_in}};
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign rdata    = rdata_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_memctrl_rr.sv
// Directed self-checking bench for memctrl_rr with a small byte-RAM model.
module tb_memctrl_rr;

  localparam int NCH = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              rdy_in = 1'b1;
  logic              clear = 1'b0;
  logic [7:0]        mem_din = '0;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;
  logic              io_buffer_full = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    we = '0;
  logic [2*NCH-1:0]  size = '0;
  logic [NCH-1:0]    uns = '0;
  logic [32*NCH-1:0] addr = '0;
  logic [32*NCH-1:0] wdata = '0;
  logic [NCH-1:0]    done;
  logic [31:0]       rdata;
  logic              busy;

  memctrl_rr #(.NUM_CH(NCH), .ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .req(req), .we(we), .size(size),
    .uns(uns), .addr(addr), .wdata(wdata), .done(done), .rdata(rdata),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  int          wr_count = 0;

  always @(posedge clk_in) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task automatic setup_ch(input int ch, input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd);
    we[ch] = w;
    size[ch*2 +: 2] = sz;
    uns[ch] = un;
    addr[ch*32 +: 32] = a;
    wdata[ch*32 +: 32] = wd;
  endtask

  // Raises req in cycle G, waits for done, checks latency/channel/rdata, drops req.
  task automatic do_access(input string tag, input int ch, input logic w, input logic [1:0] sz,
                           input logic un, input logic [31:0] a, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd);
    int lat;
    logic [NCH-1:0] onehot;
    setup_ch(ch, w, sz, un, a, wd);
    req[ch] = 1'b1;
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (done != '0) break;
    end
    onehot = '0;
    onehot[ch] = 1'b1;
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_done"}, 32'(done), 32'(onehot));
    if (!w) check_eq({tag, "_rdata"}, rdata, exp_rd);
    req[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int cnt;
    int lat;
    logic [NCH-1:0] exp_seq [4];
    logic [NCH-1:0] seen;

    // Reset, with clear asserted too: reset must win
    clear = 1'b1;
    repeat (3) step();
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    rst_in = 1'b0;
    clear = 1'b0;

    poke(12'h100, 8'h80);
    poke(12'h102, 8'h34);
    poke(12'h103, 8'h92);
    poke(12'h040, 8'h7F);

    do_access("rd_b_s", 0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 3, 32'hFFFF_FF80);
    do_access("rd_b_u", 0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 3, 32'h0000_0080);
    do_access("rd_h_s", 0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 4, 32'hFFFF_9234);

    // Word write on ch1: byte sequence on the bus
    w0 = wr_count;
    setup_ch(1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h1122_3344);
    req[1] = 1'b1;
    step();
    check_eq("ww_a0", mem_a, 32'h200);
    check_eq("ww_d0", 32'(mem_dout), 32'h44);
    check_eq("ww_w0", 32'(mem_wr), 32'd1);
    step();
    check_eq("ww_a1", mem_a, 32'h201);
    check_eq("ww_d1", 32'(mem_dout), 32'h33);
    step();
    check_eq("ww_a2", mem_a, 32'h202);
    check_eq("ww_d2", 32'(mem_dout), 32'h22);
    step();
    check_eq("ww_a3", mem_a, 32'h203);
    check_eq("ww_d3", 32'(mem_dout), 32'h11);
    check_eq("ww_w3", 32'(mem_wr), 32'd1);
    step();
    check_eq("ww_done", 32'(done), 32'b10);
    check_eq("ww_wr_off", 32'(mem_wr), 32'd0);
    req[1] = 1'b0;
    check_eq("ww_count", 32'(wr_count - w0), 32'd4);
    check_eq("ww_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'h1122_3344);

    // Round robin: both hold req, completions alternate 0,1,0,1
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    setup_ch(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0);
    setup_ch(1, 1'b0, 2'd0, 1'b0, 32'h040, 32'h0);
    req = 2'b11;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done != '0) begin
        check_eq($sformatf("rr_%0d", cnt), 32'(done), 32'(exp_seq[cnt]));
        cnt++;
        if (cnt == 4) begin
          req = '0;
          break;
        end
      end
    end
    req = '0;
    check_eq("rr_count", 32'(cnt), 32'd4);

    // IO back-pressure: ch0 IO write is held off while the buffer is full
    io_buffer_full = 1'b1;
    setup_ch(0, 1'b1, 2'd0, 1'b0, 32'h3_0000, 32'h0000_005A);
    setup_ch(1, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
    req = 2'b11;
    step();
    check_eq("io_first_a", mem_a, 32'h40);
    check_eq("io_first_wr", 32'(mem_wr), 32'd0);
    lat = 1;
    while (lat < 20 && done == '0) begin
      step();
      lat++;
    end
    check_eq("io_ch1_done", 32'(done), 32'b10);
    check_eq("io_ch1_rdata", rdata, 32'h0000_007F);
    req[1] = 1'b0;
    step();
    check_eq("io_blocked1", 32'(busy), 32'd0);
    step();
    check_eq("io_blocked2", 32'(busy), 32'd0);
    io_buffer_full = 1'b0;
    step();
    check_eq("io_ch0_a", mem_a, 32'h3_0000);
    check_eq("io_ch0_wr", 32'(mem_wr), 32'd1);
    check_eq("io_ch0_d", 32'(mem_dout), 32'h5A);
    step();
    check_eq("io_ch0_done", 32'(done), 32'b01);
    req[0] = 1'b0;

    // Clear during a word read: abort, no done
    setup_ch(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    req[0] = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    check_eq("clr_rd_busy", 32'(busy), 32'd0);
    check_eq("clr_rd_done", 32'(done), 32'd0);
    clear = 1'b0;
    req[0] = 1'b0;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      seen |= done;
    end
    check_eq("clr_rd_nodone", 32'(seen), 32'd0);
    check_eq("clr_rd_rdata", rdata, 32'd0);

    // Clear during a word write: all bytes still written, done pulses
    w0 = wr_count;
    setup_ch(1, 1'b1, 2'd2, 1'b0, 32'h300, 32'hA1B2_C3D4);
    req[1] = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    lat = 3;
    while (lat < 20 && done == '0) begin
      step();
      lat++;
    end
    check_eq("clr_wr_lat", 32'(lat), 32'd5);
    check_eq("clr_wr_done", 32'(done), 32'b10);
    req[1] = 1'b0;
    check_eq("clr_wr_count", 32'(wr_count - w0), 32'd4);
    check_eq("clr_wr_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'hA1B2_C3D4);

    // rdy_in low for 3 cycles during the second byte of a half write
    w0 = wr_count;
    setup_ch(0, 1'b1, 2'd1, 1'b0, 32'h400, 32'h0000_BEEF);
    req[0] = 1'b1;
    step();
    check_eq("rdy_b0_a", mem_a, 32'h400);
    check_eq("rdy_b0_wr", 32'(mem_wr), 32'd1);
    step();
    rdy_in = 1'b0;
    #1;
    check_eq("rdy_lo1_wr", 32'(mem_wr), 32'd0);
    check_eq("rdy_lo1_a", mem_a, 32'h401);
    step();
    check_eq("rdy_lo2_wr", 32'(mem_wr), 32'd0);
    check_eq("rdy_lo2_a", mem_a, 32'h401);
    check_eq("rdy_lo2_done", 32'(done), 32'd0);
    step();
    check_eq("rdy_lo3_wr", 32'(mem_wr), 32'd0);
    check_eq("rdy_lo3_a", mem_a, 32'h401);
    step();
    rdy_in = 1'b1;
    #1;
    check_eq("rdy_b1_wr", 32'(mem_wr), 32'd1);
    check_eq("rdy_b1_a", mem_a, 32'h401);
    check_eq("rdy_b1_d", 32'(mem_dout), 32'hBE);
    step();
    check_eq("rdy_done", 32'(done), 32'b01);
    req[0] = 1'b0;
    check_eq("rdy_count", 32'(wr_count - w0), 32'd2);
    check_eq("rdy_ram", 32'({ram[12'h401], ram[12'h400]}), 32'h0000_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
